// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command decoder: opcodes, FSM states and
// the coordinate type used for window and pointer registers.
package lcd_pkg;

    localparam int COORD_W = 9;
    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [7:0] CMD_CASET      = 8'h2A;
    localparam logic [7:0] CMD_PASET      = 8'h2B;
    localparam logic [7:0] CMD_RAMWR      = 8'h2C;
    localparam logic [7:0] CMD_RAMWR_CONT = 8'h3C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_PASET = 2'd2,
        ST_RAMWR = 2'd3
    } lcd_state_e;

    // Saturate a 16-bit bus address to the highest legal coordinate.
    function automatic coord_t clamp_coord(input logic [15:0] v, input coord_t max_v);
        return (v > 16'(max_v)) ? max_v : v[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus wr rising-edge
// detection qualified by chip select.
module lcd_bus_sync (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lcd_wr,
    input  logic        i_lcd_rs,
    input  logic        i_lcd_cs_n,
    input  logic        i_lcd_rst_n,
    input  logic [15:0] i_lcd_data,
    output logic        o_wr_stb,
    output logic        o_rs,
    output logic        o_lcd_rst_n,
    output logic [15:0] o_data
);

    // Bit order {wr, rs, cs_n, lcd_rst_n, data}; idle levels keep the bus inert.
    localparam logic [19:0] IDLE_LVL = {1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};

    logic [19:0] meta;
    logic [19:0] sync;
    logic        wr_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta    <= IDLE_LVL;
            sync    <= IDLE_LVL;
            wr_prev <= 1'b1;
        end else begin
            meta    <= {i_lcd_wr, i_lcd_rs, i_lcd_cs_n, i_lcd_rst_n, i_lcd_data};
            sync    <= meta;
            wr_prev <= sync[19];
        end
    end

    // Bits sync independently; the bus is held stable around each wr edge.
    assign o_wr_stb    = sync[19] & ~wr_prev & ~sync[17];
    assign o_rs        = sync[18];
    assign o_lcd_rst_n = sync[16];
    assign o_data      = sync[15:0];

endmodule

// File: rtl/lcd_cmd_decoder.sv
// LCD bus command decoder: tracks the CASET/PASET window and turns RAMWR
// parameters into pixel strobes with auto-advancing (x, y) coordinates.
module lcd_cmd_decoder
    import lcd_pkg::*;
#(
    parameter int COL_MAX = 319,
    parameter int ROW_MAX = 479
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_lcd_wr,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_cs_n,
    input  logic       i_lcd_rst_n,
    input  logic [15:0] i_lcd_data,
    output logic       o_pix_valid,
    output coord_t     o_pix_x,
    output coord_t     o_pix_y,
    output logic [15:0] o_pix_data,
    output logic       o_frame_start,
    output logic       o_frame_done,
    output lcd_state_e o_dbg_state
);

    localparam coord_t COL_LIM = coord_t'(COL_MAX);
    localparam coord_t ROW_LIM = coord_t'(ROW_MAX);

    logic        wr_stb;
    logic        rs_s;
    logic        lcd_rst_s;
    logic [15:0] data_s;

    lcd_bus_sync u_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lcd_wr    (i_lcd_wr),
        .i_lcd_rs    (i_lcd_rs),
        .i_lcd_cs_n  (i_lcd_cs_n),
        .i_lcd_rst_n (i_lcd_rst_n),
        .i_lcd_data  (i_lcd_data),
        .o_wr_stb    (wr_stb),
        .o_rs        (rs_s),
        .o_lcd_rst_n (lcd_rst_s),
        .o_data      (data_s)
    );

    lcd_state_e state, state_nxt;
    logic [1:0] pcnt;
    logic [7:0] p_hi_s, p_lo_s, p_hi_e;
    coord_t     sc, ec, sp, ep, x_ptr, y_ptr;
    coord_t     win_max, win_s, clamp_e, win_e;
    logic       cmd_stb, par_stb, commit, last_pix;

    assign cmd_stb  = wr_stb & ~rs_s;
    assign par_stb  = wr_stb & rs_s;
    assign commit   = par_stb && (state == ST_CASET || state == ST_PASET) && (pcnt == 2'd3);
    assign last_pix = (x_ptr == ec) && (y_ptr == ep);

    // Window candidate formed from the three buffered bytes plus the 4th on the bus.
    always_comb begin
        win_max = (state == ST_PASET) ? ROW_LIM : COL_LIM;
        win_s   = clamp_coord({p_hi_s, p_lo_s}, win_max);
        clamp_e = clamp_coord({p_hi_e, data_s[7:0]}, win_max);
        win_e   = (clamp_e < win_s) ? win_s : clamp_e;
    end

    always_comb begin
        state_nxt = state;
        if (cmd_stb) begin
            case (data_s[7:0])
                CMD_CASET:      state_nxt = ST_CASET;
                CMD_PASET:      state_nxt = ST_PASET;
                CMD_RAMWR:      state_nxt = ST_RAMWR;
                CMD_RAMWR_CONT: state_nxt = ST_RAMWR;
                default:        state_nxt = ST_IDLE;
            endcase
        end else if (commit) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else if (!lcd_rst_s) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A low synchronized lcd_rst_n behaves like the async reset but clocked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pcnt          <= '0;
            p_hi_s        <= '0;
            p_lo_s        <= '0;
            p_hi_e        <= '0;
            sc            <= '0;
            sp            <= '0;
            ec            <= COL_LIM;
            ep            <= ROW_LIM;
            x_ptr         <= '0;
            y_ptr         <= '0;
            o_pix_valid   <= 1'b0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_pix_data    <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
        end else if (!lcd_rst_s) begin
            pcnt          <= '0;
            p_hi_s        <= '0;
            p_lo_s        <= '0;
            p_hi_e        <= '0;
            sc            <= '0;
            sp            <= '0;
            ec            <= COL_LIM;
            ep            <= ROW_LIM;
            x_ptr         <= '0;
            y_ptr         <= '0;
            o_pix_valid   <= 1'b0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_pix_data    <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            o_pix_valid   <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            if (cmd_stb) begin
                pcnt <= '0;
                if (data_s[7:0] == CMD_RAMWR) begin
                    x_ptr         <= sc;
                    y_ptr         <= sp;
                    o_frame_start <= 1'b1;
                end
            end else if (par_stb) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        pcnt <= pcnt + 2'd1;
                        case (pcnt)
                            2'd0: p_hi_s <= data_s[7:0];
                            2'd1: p_lo_s <= data_s[7:0];
                            2'd2: p_hi_e <= data_s[7:0];
                            default: begin
                                if (state == ST_CASET) begin
                                    sc <= win_s;
                                    ec <= win_e;
                                end else begin
                                    sp <= win_s;
                                    ep <= win_e;
                                end
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        o_pix_valid  <= 1'b1;
                        o_pix_x      <= x_ptr;
                        o_pix_y      <= y_ptr;
                        o_pix_data   <= data_s;
                        o_frame_done <= last_pix;
                        if (x_ptr != ec) begin
                            x_ptr <= x_ptr + coord_t'(1);
                        end else begin
                            x_ptr <= sc;
                            y_ptr <= last_pix ? sp : y_ptr + coord_t'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_lcd_cmd_decoder.sv
// Bench for lcd_cmd_decoder: directed scenarios with literal pixel
// expectations, then randomized bus traffic against a window/pointer model.
module tb_lcd_cmd_decoder;
    import lcd_pkg::*;

    localparam int COL_MAX = 319;
    localparam int ROW_MAX = 479;
    localparam int W = 35;   // {x[8:0], y[8:0], data[15:0], done}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lcd_wr = 1'b1;
    logic        lcd_rs = 1'b0;
    logic        lcd_cs_n = 1'b1;
    logic        lcd_rst_n = 1'b1;
    logic [15:0] lcd_data = 16'h0000;
    logic        pix_valid;
    coord_t      pix_x, pix_y;
    logic [15:0] pix_data;
    logic        frame_start, frame_done;
    lcd_state_e  dbg_state;

    lcd_cmd_decoder #(.COL_MAX(COL_MAX), .ROW_MAX(ROW_MAX)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_lcd_wr      (lcd_wr),
        .i_lcd_rs      (lcd_rs),
        .i_lcd_cs_n    (lcd_cs_n),
        .i_lcd_rst_n   (lcd_rst_n),
        .i_lcd_data    (lcd_data),
        .o_pix_valid   (pix_valid),
        .o_pix_x       (pix_x),
        .o_pix_y       (pix_y),
        .o_pix_data    (pix_data),
        .o_frame_start (frame_start),
        .o_frame_done  (frame_done),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int exp_start  = 0;
    int start_seen = 0;

    // Reference model: window, pointer and mode (0 idle, 1 col, 2 row, 3 ramwr).
    int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_mode, m_cnt;
    int m_p[4];

    task automatic model_reset();
        m_sc = 0; m_sp = 0; m_ec = COL_MAX; m_ep = ROW_MAX;
        m_x = 0; m_y = 0; m_mode = 0; m_cnt = 0;
    endtask

    task automatic model_write(input logic rs, input logic [15:0] d, input logic cs_n);
        int b, lim, s, e;
        logic done;
        b = int'(d[7:0]);
        if (cs_n) return;
        if (!rs) begin
            m_cnt = 0;
            case (b)
                'h2A: m_mode = 1;
                'h2B: m_mode = 2;
                'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; exp_start++; end
                'h3C: m_mode = 3;
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            m_p[m_cnt] = b;
            m_cnt++;
            if (m_cnt == 4) begin
                lim = (m_mode == 1) ? COL_MAX : ROW_MAX;
                s = m_p[0] * 256 + m_p[1];
                e = m_p[2] * 256 + m_p[3];
                if (s > lim) s = lim;
                if (e > lim) e = lim;
                if (e < s) e = s;
                if (m_mode == 1) begin m_sc = s; m_ec = e; end
                else begin m_sp = s; m_ep = e; end
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            done = (m_x == m_ec) && (m_y == m_ep);
            exp_q.push_back({9'(m_x), 9'(m_y), d, done});
            if (m_x != m_ec) m_x = (m_x + 1) % 512;
            else if (m_y != m_ep) begin m_x = m_sc; m_y = (m_y + 1) % 512; end
            else begin m_x = m_sc; m_y = m_sp; end
        end
    endtask

    // Driver tasks
    task automatic bus_write(input logic rs, input logic [15:0] d, input logic cs_n);
        @(negedge clk);
        lcd_cs_n = cs_n; lcd_rs = rs; lcd_data = d; lcd_wr = 1'b0;
        repeat (4) @(negedge clk);
        lcd_wr = 1'b1;
        model_write(rs, d, cs_n);
        repeat (5) @(negedge clk);
        lcd_cs_n = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] c);
        bus_write(1'b0, {8'h00, c}, 1'b0);
    endtask

    task automatic par(input logic [15:0] d);
        bus_write(1'b1, d, 1'b0);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic lcd_reset_pulse();
        @(negedge clk);
        lcd_rst_n = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        lcd_rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_val(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_pix(input string nm, input int idx, input int ex, input int ey,
                             input int ed, input int edone);
        logic [W-1:0] o;
        total++;
        if (idx >= obs_q.size()) begin
            bad++;
            $display("FAIL %s: pixel %0d missing (have %0d)", nm, idx, obs_q.size());
        end else begin
            o = obs_q[idx];
            if (int'(o[34:26]) != ex || int'(o[25:17]) != ey || int'(o[16:1]) != ed || int'(o[0]) != edone) begin
                bad++;
                $display("FAIL %s: got x=%0d y=%0d d=%h done=%0d expected x=%0d y=%0d d=%h done=%0d",
                         nm, o[34:26], o[25:17], o[16:1], o[0], ex, ey, ed[15:0], edone);
            end
        end
    endtask

    // Scoreboard: every DUT pixel is matched against the model in order.
    always @(posedge clk) begin
        logic [W-1:0] got, e;
        #1;
        if (rst_n) begin
            got = {pix_x, pix_y, pix_data, frame_done};
            if (pix_valid) begin
                total++;
                obs_q.push_back(got);
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d d=%h, none expected",
                             pix_x, pix_y, pix_data);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL pixel_vs_model: got x=%0d y=%0d d=%h done=%0d expected x=%0d y=%0d d=%h done=%0d",
                                 pix_x, pix_y, pix_data, frame_done, e[34:26], e[25:17], e[16:1], e[0]);
                    end
                end
            end else begin
                total++;
                if (frame_done) begin
                    bad++;
                    $display("FAIL done_without_pixel: frame_done=1 with pix_valid=0");
                end
            end
            if (frame_start) start_seen++;
        end
    end

    task automatic window_cmd(input logic [7:0] c);
        int s, e;
        s = $urandom_range(0, 520);
        e = s + $urandom_range(0, 3);
        if ($urandom_range(0, 5) == 0) e = (s >= 5) ? s - 5 : 0;
        cmd(c);
        par({8'($urandom_range(0, 255)), 8'(s / 256)});
        par({8'($urandom_range(0, 255)), 8'(s % 256)});
        par({8'($urandom_range(0, 255)), 8'(e / 256)});
        par({8'($urandom_range(0, 255)), 8'(e % 256)});
    endtask

    initial begin
        int s0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_pix_valid", int'(pix_valid), 0);
        check_val("rst_pix_x", int'(pix_x), 0);
        check_val("rst_pix_y", int'(pix_y), 0);
        check_val("rst_pix_data", int'(pix_data), 0);
        check_val("rst_frame_start", int'(frame_start), 0);
        check_val("rst_frame_done", int'(frame_done), 0);
        check_val("rst_state", int'(dbg_state), int'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain RAMWR after reset
        obs_q.delete(); s0 = start_seen;
        cmd(8'h2C); par(16'hA001); par(16'hB002); par(16'hC003);
        repeat (4) @(negedge clk);
        check_val("t1_count", obs_q.size(), 3);
        check_pix("t1_p0", 0, 0, 0, 'hA001, 0);
        check_pix("t1_p1", 1, 1, 0, 'hB002, 0);
        check_pix("t1_p2", 2, 2, 0, 'hC003, 0);
        check_val("t1_start", start_seen - s0, 1);

        // 2x2 window with wrap and frame_done
        obs_q.delete();
        cmd(8'h2A); par(16'h0000); par(16'h000A); par(16'h0000); par(16'h000B);
        cmd(8'h2B); par(16'h0000); par(16'h0005); par(16'h0000); par(16'h0006);
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) par(16'h1000 + 16'(i));
        repeat (4) @(negedge clk);
        check_pix("t2_p0", 0, 10, 5, 'h1000, 0);
        check_pix("t2_p1", 1, 11, 5, 'h1001, 0);
        check_pix("t2_p2", 2, 10, 6, 'h1002, 0);
        check_pix("t2_p3", 3, 11, 6, 'h1003, 1);
        check_pix("t2_p4", 4, 10, 5, 'h1004, 0);

        // Partial CASET keeps previous window
        obs_q.delete();
        cmd(8'h2A); par(16'h0000); par(16'h0020);
        cmd(8'h2C); par(16'h2222);
        repeat (4) @(negedge clk);
        check_pix("t3_old_sc", 0, 10, 5, 'h2222, 0);

        // Clamp: SC=0x1FF -> 319, EC=5 -> forced to SC
        obs_q.delete();
        cmd(8'h2A); par(16'h0001); par(16'h00FF); par(16'h0000); par(16'h0005);
        cmd(8'h2C); par(16'h3330); par(16'h3331); par(16'h3332);
        repeat (4) @(negedge clk);
        check_pix("t4_p0", 0, 319, 5, 'h3330, 0);
        check_pix("t4_p1", 1, 319, 6, 'h3331, 1);
        check_pix("t4_p2", 2, 319, 5, 'h3332, 0);

        // cs_n=1 writes ignored; 0x3C continues the pointer
        hard_reset();
        obs_q.delete(); s0 = start_seen;
        cmd(8'h2C); par(16'h4440); par(16'h4441);
        bus_write(1'b1, 16'h5555, 1'b1);
        bus_write(1'b0, 16'h002C, 1'b1);
        bus_write(1'b1, 16'h6666, 1'b1);
        repeat (4) @(negedge clk);
        check_val("t5_cs_ignored", obs_q.size(), 2);
        cmd(8'h3C); par(16'h4442);
        repeat (4) @(negedge clk);
        check_pix("t5_p0", 0, 0, 0, 'h4440, 0);
        check_pix("t5_p1", 1, 1, 0, 'h4441, 0);
        check_pix("t5_cont", 2, 2, 0, 'h4442, 0);
        check_val("t5_start", start_seen - s0, 1);

        // lcd_rst_n mid-frame aborts RAMWR without done
        hard_reset();
        obs_q.delete();
        cmd(8'h2A); par(16'h0000); par(16'h0003); par(16'h0000); par(16'h0004);
        cmd(8'h2C); par(16'h7770); par(16'h7771);
        lcd_reset_pulse();
        check_val("t6_state_after_lcd_rst", int'(dbg_state), int'(ST_IDLE));
        par(16'h7772); par(16'h7773);
        repeat (4) @(negedge clk);
        check_val("t6_suppressed", obs_q.size(), 2);
        cmd(8'h2C); par(16'h7774);
        repeat (4) @(negedge clk);
        check_pix("t6_restart", 2, 0, 0, 'h7774, 0);

        // Randomized traffic against the model
        hard_reset();
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 11))
                0: window_cmd(8'h2A);
                1: window_cmd(8'h2B);
                2: begin
                    cmd($urandom_range(0, 1) ? 8'h2A : 8'h2B);
                    for (int k = 0; k < int'($urandom_range(0, 3)); k++) par(16'($urandom));
                end
                3, 4: cmd(8'h2C);
                5: cmd(8'h3C);
                6: cmd(8'($urandom_range(0, 255)));
                7: bus_write(1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
                8: if ($urandom_range(0, 3) == 0) lcd_reset_pulse();
                default: for (int k = 0; k < int'($urandom_range(1, 6)); k++) par(16'($urandom));
            endcase
        end
        repeat (6) @(negedge clk);
        check_val("end_exp_q_empty", exp_q.size(), 0);
        check_val("frame_start_count", start_seen, exp_start);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
